// File: rtl/st4_mem_pkg.sv
// Shared encodings and byte-lane helpers for the stage-4 data memory controller.
// Helpers work on a 32-bit container; callers truncate to their DATA_W.
package st4_mem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_HALF = 2'b11;

    typedef enum logic {CLEAR, RUN} state_t;

    // Access width in bytes; a halfword on a word no wider than 16 bits is a word access.
    function automatic int size_bytes(logic [1:0] size, int nb);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return (nb <= 2) ? nb : 2;
            SZ_WORD: return nb;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] lane, int nb);
        logic [3:0] full;
        full = (nb == 4) ? 4'hF : (nb == 2) ? 4'h3 : 4'h1;
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return (nb <= 2) ? full : (4'b0011 << lane);
            SZ_WORD: return full;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(logic [31:0] word, logic [1:0] size,
                                                 logic [1:0] lane, logic uns, int nb);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: begin
                if (nb <= 2) return sh;
                return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            SZ_WORD: return sh;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/st4_mem_array.sv
// DEPTH x DATA_W RAM with per-byte write enables on the clock edge and a
// combinational read port.
module st4_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    localparam int NB    = DATA_W / 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [NB-1:0]     we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the controller's CLEAR sequence zeroes it.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/st4_data_memory_ctrl.sv
// Stage-4 (MEM) data memory controller: post-reset clear, byte/half/word access,
// alignment and range faults, registered extended load result.
module st4_data_memory_ctrl
    import st4_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        MemWrite,
    input  logic [1:0]        MemRead,
    input  logic              LoadUnsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Ready,
    output logic              Fault,
    output logic [ADDR_W-1:0] FaultAddr
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [AW-1:0]     clr_cnt;
    logic [ADDR_W-1:0] idx_full;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    int                acc_bytes;
    logic              active, misaligned, out_of_range, fault, do_write, do_read;
    logic [NB-1:0]     we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              rd_pend, rd_uns;
    logic [AW-1:0]     rd_idx;
    logic [1:0]        rd_size, rd_lane;

    assign Ready    = (state == RUN);
    assign idx_full = Address >> LB;
    assign idx      = idx_full[AW-1:0];
    assign lane     = 2'(Address & ADDR_W'(NB - 1));

    // A combined store+load is checked against the wider of the two sizes.
    always_comb begin
        acc_bytes    = (size_bytes(MemWrite, NB) > size_bytes(MemRead, NB))
                       ? size_bytes(MemWrite, NB) : size_bytes(MemRead, NB);
        active       = Ready && (acc_bytes != 0);
        misaligned   = (32'(lane) & 32'(acc_bytes - 1)) != 32'h0;
        out_of_range = 32'(idx_full) >= 32'(DEPTH);
        fault        = active && (misaligned || out_of_range);
        do_write     = active && !fault && !rst && (MemWrite != SZ_NONE);
        do_read      = active && !fault && (MemRead != SZ_NONE);
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        we        = '0;
        waddr     = idx;
        wdata     = WriteData << {lane, 3'b000};
        case (state)
            CLEAR: begin
                we    = '1;
                waddr = clr_cnt;
                wdata = '0;
                if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN: if (do_write) we = NB'(lane_mask(MemWrite, lane, NB));
            default: state_nxt = CLEAR;
        endcase
    end

    st4_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            ReadData  <= '0;
            ReadValid <= 1'b0;
            Fault     <= 1'b0;
            FaultAddr <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
            Fault     <= fault;
            if (fault) FaultAddr <= Address;
            rd_pend   <= do_read;
            ReadValid <= rd_pend;
            if (rd_pend)
                ReadData <= DATA_W'(load_extract(32'(rdata), rd_size, rd_lane, rd_uns, NB));
        end
    end

    // The array is read one edge after the request, so a same-cycle store is already visible.
    always_ff @(posedge clk) begin
        if (do_read) begin
            rd_idx  <= idx;
            rd_size <= MemRead;
            rd_lane <= lane;
            rd_uns  <= LoadUnsigned;
        end
    end

endmodule

// File: tb/tb_st4_data_memory_ctrl.sv
// Directed bench: a 16-bit/256-word instance and a 32-bit/16-word instance.
module tb_st4_data_memory_ctrl;

    localparam logic [1:0] N = 2'b00, W = 2'b01, B = 2'b10, H = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  mw16 = N, mr16 = N, mw32 = N, mr32 = N;
    logic        lu16 = 1'b0, lu32 = 1'b0;
    logic [15:0] ad16 = '0, ad32 = '0;
    logic [15:0] wd16 = '0;
    logic [31:0] wd32 = '0;
    logic [15:0] rdata16, fa16, fa32;
    logic [31:0] rdata32;
    logic        rv16, rdy16, flt16, rv32, rdy32, flt32;

    st4_data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) u_dut16 (
        .clk(clk), .rst(rst), .MemWrite(mw16), .MemRead(mr16), .LoadUnsigned(lu16),
        .Address(ad16), .WriteData(wd16), .ReadData(rdata16), .ReadValid(rv16),
        .Ready(rdy16), .Fault(flt16), .FaultAddr(fa16));

    st4_data_memory_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(16)) u_dut32 (
        .clk(clk), .rst(rst), .MemWrite(mw32), .MemRead(mr32), .LoadUnsigned(lu32),
        .Address(ad32), .WriteData(wd32), .ReadData(rdata32), .ReadValid(rv32),
        .Ready(rdy32), .Fault(flt32), .FaultAddr(fa32));

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] o_rd;
    logic [15:0] o_fa;
    logic        o_flt, o_rv0, o_rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mw16 = N; mr16 = N; lu16 = 1'b0; ad16 = '0; wd16 = '0;
        mw32 = N; mr32 = N; lu32 = 1'b0; ad32 = '0; wd32 = '0;
    endtask

    // One request cycle then one idle cycle; fault seen after the request edge, load after the next.
    task automatic access(input bit w32, input logic [1:0] wr, input logic [1:0] rd,
                          input logic uns, input logic [15:0] addr, input logic [31:0] wd);
        @(negedge clk);
        if (w32) begin
            mw32 = wr; mr32 = rd; lu32 = uns; ad32 = addr; wd32 = wd;
        end else begin
            mw16 = wr; mr16 = rd; lu16 = uns; ad16 = addr; wd16 = wd[15:0];
        end
        @(posedge clk); #1;
        o_flt = w32 ? flt32 : flt16;
        o_fa  = w32 ? fa32 : fa16;
        o_rv0 = w32 ? rv32 : rv16;
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        o_rd = w32 ? rdata32 : {16'h0, rdata16};
        o_rv = w32 ? rv32 : rv16;
    endtask

    // Called on the negedge where rst has just dropped; counts cycles with Ready=0.
    task automatic wait_clear(input int exp16, input int exp32, input string tag);
        int  n16 = 0, n32 = 0;
        bit  spur = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (rdy16 && rdy32) break;
            if (!rdy16) n16++;
            if (!rdy32) n32++;
            if (flt16 || rv16) spur = 1'b1;
            @(negedge clk);
        end
        idle();
        check({tag, "_clear16_cycles"}, n16, exp16);
        check({tag, "_clear32_cycles"}, n32, exp32);
        check({tag, "_ignored_while_busy"}, {31'h0, spur}, 32'h0);
        check({tag, "_ready16"}, {31'h0, rdy16}, 32'h1);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_readdata", {16'h0, rdata16}, 32'h0);
        check("rst_readvalid", {31'h0, rv16}, 32'h0);
        check("rst_fault", {31'h0, flt16}, 32'h0);
        check("rst_faultaddr", {16'h0, fa16}, 32'h0);
        check("rst_ready", {31'h0, rdy16}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // Misaligned store+load held during CLEAR must be ignored
        mw16 = W; mr16 = W; ad16 = 16'h0001; wd16 = 16'hDEAD;
        wait_clear(256, 16, "first");

        // First load after clear, with latency check
        access(0, N, W, 0, 16'h0000, 32'h0);
        check("load0_early_valid", {31'h0, o_rv0}, 32'h0);
        check("load0_data", o_rd, 32'h0);
        check("load0_valid", {31'h0, o_rv}, 32'h1);

        // Word store/load and misaligned store
        access(0, W, N, 0, 16'h0002, 32'h8888);
        access(0, N, W, 0, 16'h0002, 32'h0);
        check("word_load_2", o_rd, 32'h8888);
        access(0, W, N, 0, 16'h0000, 32'h5555);
        access(0, W, N, 0, 16'h0001, 32'h7777);
        check("misalign_fault", {31'h0, o_flt}, 32'h1);
        check("misalign_faddr", {16'h0, o_fa}, 32'h0001);
        access(0, N, W, 0, 16'h0000, 32'h0);
        check("misalign_unchanged", o_rd, 32'h5555);

        // Byte store into the high lane, then extended loads
        access(0, W, N, 0, 16'h000A, 32'h1234);
        access(0, B, N, 0, 16'h000B, 32'hFFF8);
        access(0, N, B, 0, 16'h000B, 32'h0);
        check("byte_signed", o_rd, 32'hFFF8);
        access(0, N, B, 1, 16'h000B, 32'h0);
        check("byte_unsigned", o_rd, 32'h00F8);
        access(0, N, W, 0, 16'h000A, 32'h0);
        check("byte_word_merge", o_rd, 32'hF834);
        access(0, N, B, 0, 16'h000A, 32'h0);
        check("byte_low_lane", o_rd, 32'h0034);

        // Halfword code on a 16-bit word behaves as a word access
        access(0, N, H, 0, 16'h0003, 32'h0);
        check("half16_misalign_fault", {31'h0, o_flt}, 32'h1);
        access(0, N, H, 0, 16'h000A, 32'h0);
        check("half16_as_word", o_rd, 32'hF834);

        // Simultaneous store and load: write-first
        access(0, W, W, 0, 16'h0010, 32'h1234);
        check("wr_rd_same_data", o_rd, 32'h1234);
        check("wr_rd_same_valid", {31'h0, o_rv}, 32'h1);

        // Out-of-range and wider-size check on combined access
        access(0, N, W, 0, 16'h0200, 32'h0);
        check("range_fault", {31'h0, o_flt}, 32'h1);
        check("range_faddr", {16'h0, o_fa}, 32'h0200);
        check("range_no_valid", {31'h0, o_rv}, 32'h0);
        access(0, B, W, 0, 16'h0013, 32'h00AB);
        check("combo_wider_fault", {31'h0, o_flt}, 32'h1);
        access(0, N, B, 1, 16'h0013, 32'h0);
        check("combo_blocked_write", o_rd, 32'h0000);

        // 32-bit instance
        access(1, H, N, 0, 16'h0006, 32'h1234BEEF);
        access(1, N, H, 0, 16'h0006, 32'h0);
        check("w32_half_signed", o_rd, 32'hFFFFBEEF);
        access(1, N, H, 1, 16'h0006, 32'h0);
        check("w32_half_unsigned", o_rd, 32'h0000BEEF);
        access(1, N, W, 0, 16'h0004, 32'h0);
        check("w32_word_4", o_rd, 32'hBEEF0000);
        access(1, N, H, 0, 16'h0005, 32'h0);
        check("w32_half_misalign", {31'h0, o_flt}, 32'h1);
        check("w32_half_misalign_faddr", {16'h0, o_fa}, 32'h0005);
        access(1, N, B, 0, 16'h0007, 32'h0);
        check("w32_byte_signed", o_rd, 32'hFFFFFFBE);
        access(1, W, N, 0, 16'h0040, 32'hCAFEF00D);
        check("w32_range_fault", {31'h0, o_flt}, 32'h1);
        access(1, N, W, 0, 16'h0002, 32'h0);
        check("w32_word_misalign", {31'h0, o_flt}, 32'h1);
        access(1, B, N, 0, 16'h0004, 32'h000000AA);
        access(1, N, W, 0, 16'h0004, 32'h0);
        check("w32_byte_merge", o_rd, 32'hBEEF00AA);

        // Reset mid-RUN with a store pending
        access(0, N, W, 0, 16'h0002, 32'h0);
        check("pre_reset_load", o_rd, 32'h8888);
        @(negedge clk);
        rst = 1'b1;
        mw16 = W; ad16 = 16'h0020; wd16 = 16'hABCD;
        @(posedge clk); #1;
        check("midrst_readdata", {16'h0, rdata16}, 32'h0);
        check("midrst_readvalid", {31'h0, rv16}, 32'h0);
        check("midrst_fault", {31'h0, flt16}, 32'h0);
        check("midrst_faultaddr", {16'h0, fa16}, 32'h0);
        check("midrst_ready", {31'h0, rdy16}, 32'h0);
        check("midrst_readdata32", rdata32, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        wait_clear(256, 16, "second");
        access(0, N, W, 0, 16'h0020, 32'h0);
        check("post_rst_dropped_store", o_rd, 32'h0);
        access(0, N, W, 0, 16'h0010, 32'h0);
        check("post_rst_cleared", o_rd, 32'h0);
        check("post_rst_valid", {31'h0, o_rv}, 32'h1);
        access(1, N, W, 0, 16'h0004, 32'h0);
        check("post_rst_cleared32", o_rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
